// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between instruction fetch and the data stage.
// Define MEM_ARB_FAIRNESS_EN to cap consecutive DM grants while IF waits (MAX_DM_BURST).
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_DM_BURST   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,

  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_err_o,

  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_W/8-1:0]   dm_be_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_W-1:0]     dm_rdata_o,
  output logic                  dm_err_o,

  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_W/8-1:0]   bus_be_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  input  logic                  bus_err_i
);

  localparam int BE_W = DATA_W / 8;
  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  // IDLE: nothing in flight | REQ: bus_req_o held until bus_gnt_i | RSP: awaiting bus_rvalid_i or timeout
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic              owner_dm_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_inc;
  logic              any_req, arb_en, pick_dm, force_if;
  logic              rsp_done, rsp_timeout, rsp_any;

  logic              if_rvalid_q, dm_rvalid_q, if_err_q, dm_err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic              bus_we_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  assign any_req    = if_req_i | dm_req_i;
  assign to_cnt_inc = to_cnt_q + TO_W'(1);
  assign pick_dm    = dm_req_i & ~force_if;
  assign rsp_any    = rsp_done | rsp_timeout;

  always_comb begin
    state_d     = state_q;
    arb_en      = 1'b0;
    rsp_done    = 1'b0;
    rsp_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        // run_q keeps grants low through reset; waiting out a pending rvalid pulse keeps gnt and rvalid apart
        if (run_q && !if_rvalid_q && !dm_rvalid_q && any_req) begin
          arb_en  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus_rvalid_i) begin
          rsp_done = 1'b1;
          if (any_req) begin
            arb_en  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_inc == TO_MAX)) begin
          rsp_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      owner_dm_q  <= 1'b0;
      to_cnt_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      to_cnt_q <= ((state_q == RSP) && (state_d == RSP)) ? to_cnt_inc : '0;

      if (arb_en) begin
        owner_dm_q  <= pick_dm;
        bus_we_q    <= pick_dm & dm_we_i;
        bus_be_q    <= pick_dm ? dm_be_i : '1;
        bus_addr_q  <= pick_dm ? dm_addr_i : if_addr_i;
        bus_wdata_q <= pick_dm ? dm_wdata_i : '0;
      end

      // responses belong to the owner latched before this edge, even when re-arbitrating back-to-back
      if_rvalid_q <= rsp_any & ~owner_dm_q;
      dm_rvalid_q <= rsp_any & owner_dm_q;
      if (rsp_any && !owner_dm_q) begin
        if_rdata_q <= rsp_timeout ? '0 : bus_rdata_i;
        if_err_q   <= rsp_timeout | bus_err_i;
      end
      if (rsp_any && owner_dm_q) begin
        dm_rdata_q <= rsp_timeout ? '0 : bus_rdata_i;
        dm_err_q   <= rsp_timeout | bus_err_i;
      end
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int BURST_W = (MAX_DM_BURST > 0) ? $clog2(MAX_DM_BURST + 1) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DM_BURST);

  logic [BURST_W-1:0] burst_q;

  assign force_if = if_req_i & (burst_q >= BURST_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_q <= '0;
    end else if (!if_req_i || (arb_en && !pick_dm)) begin
      burst_q <= '0;
    end else if (arb_en && (burst_q != BURST_MAX)) begin
      burst_q <= burst_q + BURST_W'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign if_gnt_o    = arb_en & ~pick_dm;
  assign dm_gnt_o    = arb_en & pick_dm;
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = bus_we_q;
  assign bus_be_o    = bus_be_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_err_o    = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; responses checked against a queue of expected results.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o, if_err_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [BE_W-1:0]   dm_be_i = '0;
  logic [ADDR_W-1:0] dm_addr_i = '0;
  logic [DATA_W-1:0] dm_wdata_i = '0;
  logic              dm_gnt_o, dm_rvalid_o, dm_err_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              bus_req_o, bus_we_o;
  logic [BE_W-1:0]   bus_be_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
  logic [DATA_W-1:0] bus_rdata_i = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic              is_dm;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic dm, input logic [DATA_W-1:0] d, input logic e);
    exp_t r;
    r.is_dm = dm;
    r.data  = d;
    r.err   = e;
    return r;
  endfunction

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8), .MAX_DM_BURST(4)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  // response scoreboard, sampled after the drivers have settled
  always @(negedge clk_i) begin : mon
    exp_t e;
    logic [DATA_W-1:0] got_d;
    logic got_e;
    #2;
    if (rst_n_i && (if_rvalid_o || dm_rvalid_o)) begin
      checks++;
      got_d = dm_rvalid_o ? dm_rdata_o : if_rdata_o;
      got_e = dm_rvalid_o ? dm_err_o : if_err_o;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: if_rvalid=%b dm_rvalid=%b data=%h, required no response",
                 if_rvalid_o, dm_rvalid_o, got_d);
      end else begin
        e = exp_q.pop_front();
        if ((if_rvalid_o && dm_rvalid_o) || (dm_rvalid_o !== e.is_dm) || (got_d !== e.data) ||
            (got_e !== e.err) || (if_rvalid_o && if_gnt_o) || (dm_rvalid_o && dm_gnt_o)) begin
          errors++;
          $display("FAIL sb_resp: got if_rv=%b dm_rv=%b data=%h err=%b gnt=%b%b, required dm=%b data=%h err=%b",
                   if_rvalid_o, dm_rvalid_o, got_d, got_e, if_gnt_o, dm_gnt_o, e.is_dm, e.data, e.err);
        end
      end
    end
  end

  task test_reset;
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({bus_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, if_err_o, dm_err_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {bus_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, if_err_o, dm_err_o});
    end
    checks++;
    if ({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, if_rdata_o, dm_rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%h, required all 0", bus_addr_o, bus_wdata_o, bus_be_o);
    end
    if_req_i = 1'b1; dm_req_i = 1'b1;
    #1;
    checks++;
    if ({if_gnt_o, dm_gnt_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt: got %b, required 00", {if_gnt_o, dm_gnt_o});
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task test_single_fetch;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1 || dm_gnt_o !== 1'b0 || bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: got if_gnt=%b dm_gnt=%b bus_req=%b, required 1 0 0", if_gnt_o, dm_gnt_o, bus_req_o);
    end
    exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 1'b0));
    @(negedge clk_i);
    if_req_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0 || if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_busreq: got req=%b addr=%h we=%b gnt=%b, required 1 00000100 0 0",
               bus_req_o, bus_addr_o, bus_we_o, if_gnt_o);
    end
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_reqdrop: got bus_req=%b, required 0", bus_req_o);
    end
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEADBEEF || dm_rvalid_o !== 1'b0 || dm_rdata_o !== '0) begin
      errors++;
      $display("FAIL fetch_rsp: got if_rv=%b data=%h dm_rv=%b dm_data=%h, required 1 deadbeef 0 0",
               if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o);
    end
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0 || if_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_drain: got pending=%0d if_rv=%b, required 0 0", exp_q.size(), if_rvalid_o);
    end
  endtask

  task test_priority;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h300;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h200; dm_wdata_i = 32'hCAFEF00D;
    #1;
    checks++;
    if (dm_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_gnt: got dm_gnt=%b if_gnt=%b, required 1 0", dm_gnt_o, if_gnt_o);
    end
    exp_q.push_back(mk(1'b1, 32'h11111111, 1'b0));
    @(negedge clk_i);
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_wdata_i = '0;
    checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_be_o !== 4'b0011 || bus_addr_o !== 32'h200 ||
        bus_wdata_o !== 32'hCAFEF00D || if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_store: got req=%b we=%b be=%b addr=%h wdata=%h if_gnt=%b, required 1 1 0011 200 cafef00d 0",
               bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, if_gnt_o);
    end
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11111111;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1 || dm_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_b2b_gnt: got if_gnt=%b dm_gnt=%b, required 1 0", if_gnt_o, dm_gnt_o);
    end
    exp_q.push_back(mk(1'b0, 32'h22222222, 1'b0));
    @(negedge clk_i);
    bus_rvalid_i = 1'b0; if_req_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h300 || bus_we_o !== 1'b0 || dm_rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_fetch_req: got req=%b addr=%h we=%b dm_rv=%b, required 1 300 0 1",
               bus_req_o, bus_addr_o, bus_we_o, dm_rvalid_o);
    end
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h22222222;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    checks++;
    if (if_rvalid_o !== 1'b1 || dm_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_fetch_rsp: got if_rv=%b dm_rv=%b, required 1 0", if_rvalid_o, dm_rvalid_o);
    end
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL prio_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task test_timeout;
    int at;
    at = 0;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h400;
    #1;
    checks++;
    if (dm_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL to_gnt: got dm_gnt=%b, required 1", dm_gnt_o);
    end
    exp_q.push_back(mk(1'b1, 32'h0, 1'b1));
    @(negedge clk_i);
    dm_req_i = 1'b0; bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    for (int n = 3; n <= 30; n++) begin
      @(negedge clk_i);
      if (dm_rvalid_o === 1'b1 || if_rvalid_o === 1'b1) begin
        at = n;
        break;
      end
    end
    checks++;
    if (at != 10 || dm_err_o !== 1'b1 || dm_rdata_o !== '0) begin
      errors++;
      $display("FAIL to_latency: got cycle=%0d err=%b data=%h, required 10 1 0", at, dm_err_o, dm_rdata_o);
    end
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55555555;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dm_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || bus_req_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL to_late_drop: got dm_rv=%b if_rv=%b bus_req=%b pending=%0d, required 0 0 0 0",
               dm_rvalid_o, if_rvalid_o, bus_req_o, exp_q.size());
    end
  endtask

  task test_gnt_stall;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h500;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_gnt: got if_gnt=%b, required 1", if_gnt_o);
    end
    exp_q.push_back(mk(1'b0, 32'h600D600D, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if_req_i = 1'b0;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h540;
      #1;
      checks++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h500 || if_gnt_o !== 1'b0 || dm_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got req=%b addr=%h gnt=%b%b, required 1 500 00",
                 k, bus_req_o, bus_addr_o, if_gnt_o, dm_gnt_o);
      end
    end
    @(negedge clk_i);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h600D600D;
    #1;
    checks++;
    if (dm_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_b2b: got dm_gnt=%b if_gnt=%b, required 1 0", dm_gnt_o, if_gnt_o);
    end
    exp_q.push_back(mk(1'b1, 32'h0BADF00D, 1'b1));
    @(negedge clk_i);
    bus_rvalid_i = 1'b0; dm_req_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h540) begin
      errors++;
      $display("FAIL stall_dm_req: got req=%b addr=%h, required 1 540", bus_req_o, bus_addr_o);
    end
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BADF00D; bus_err_i = 1'b1;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    checks++;
    if (dm_rvalid_o !== 1'b1 || dm_err_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_dm_err: got dm_rv=%b err=%b, required 1 1", dm_rvalid_o, dm_err_o);
    end
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task test_reset_mid;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h700;
    @(negedge clk_i);
    if_req_i = 1'b0; bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({bus_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o} !== 5'b0 || bus_addr_o !== '0 || if_rdata_o !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got ctrl=%b addr=%h rdata=%h, required 0 0 0",
               {bus_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, bus_addr_o, if_rdata_o);
    end
    @(negedge clk_i);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77777777;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    bus_rvalid_i = 1'b1;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      checks++;
      if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0 || bus_req_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_lost: got if_rv=%b dm_rv=%b bus_req=%b, required 0 0 0",
                 if_rvalid_o, dm_rvalid_o, bus_req_o);
      end
    end
  endtask

  task test_fairness;
    logic [5:0] exp_order;
    int ngnt, rsp_idx;
    logic rv_next;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_order = 6'b101111;
`else
    exp_order = 6'b111111;
`endif
    ngnt = 0; rsp_idx = 0; rv_next = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h800;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h900;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_i);
      if (ngnt >= 6) begin
        if_req_i = 1'b0; dm_req_i = 1'b0;
      end
      bus_gnt_i    = bus_req_o;
      bus_rvalid_i = rv_next;
      bus_rdata_i  = 32'h1000 + rsp_idx;
      if (rv_next) rsp_idx++;
      rv_next = bus_gnt_i;
      #1;
      if ((dm_gnt_o || if_gnt_o) && ngnt < 6) begin
        checks++;
        if (dm_gnt_o !== exp_order[ngnt] || if_gnt_o !== ~exp_order[ngnt]) begin
          errors++;
          $display("FAIL fair_order[%0d]: got dm_gnt=%b if_gnt=%b, required dm_gnt=%b",
                   ngnt, dm_gnt_o, if_gnt_o, exp_order[ngnt]);
        end
        exp_q.push_back(mk(exp_order[ngnt], 32'h1000 + ngnt, 1'b0));
        ngnt++;
      end
      if (ngnt >= 6 && exp_q.size() == 0 && !rv_next && !bus_req_o) break;
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ngnt != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fair_done: got grants=%0d pending=%0d, required 6 0", ngnt, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_timeout();
    test_gnt_stall();
    test_reset_mid();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
